// File: rtl/xs_sdr_rom_arbiter_if.sv
// xs_sdr_rom_arbiter_if: bundle for the five ROM clients and the SDRAM read channel.
// slave = arbiter view (clients in, controller out); master = environment view.
interface xs_sdr_rom_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 16
);
  logic [4:0]      cli_req;
  logic [5*AW-1:0] cli_addr;
  logic [4:0]      cli_rdy;
  logic [5*DW-1:0] cli_dout;
  logic            ctl_req;
  logic [AW-1:0]   ctl_addr;
  logic            ctl_rdy;
  logic [DW-1:0]   ctl_dout;

  modport slave (
    input  cli_req, cli_addr, ctl_rdy, ctl_dout,
    output cli_rdy, cli_dout, ctl_req, ctl_addr
  );

  modport master (
    output cli_req, cli_addr, ctl_rdy, ctl_dout,
    input  cli_rdy, cli_dout, ctl_req, ctl_addr
  );
endinterface

// File: rtl/xs_sdr_rom_arbiter.sv
// xs_sdr_rom_arbiter: round-robin merge of five SDRAM ROM read ports onto one channel.
// Ports: CLK, RSTn (sync, active low), bus (slave modport: cli_* clients, ctl_* controller).
module xs_sdr_rom_arbiter #(
  parameter int AW       = 25,
  parameter int DW       = 16,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  xs_sdr_rom_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic [4:0]      pend_q, pend_d;
  logic [4:0]      rdy_q, rdy_d;
  logic [4:0]      rdy2_q;
  logic [4:0]      valid_q, valid_d;
  logic [5*AW-1:0] tag_q, tag_d;
  logic [5*DW-1:0] dout_q, dout_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      gnt_q, gnt_d;
  logic            ctl_req_q, ctl_req_d;
  logic [AW-1:0]   ctl_addr_q, ctl_addr_d;

  logic [4:0]      hit;
  logic [4:0]      miss;
  logic            pick_vld;
  logic [2:0]      pick;
  logic            fill;

  function automatic logic [2:0] rr_idx(
    input logic [2:0] p,
    input int         k
  );
    logic [3:0] s;
    s = {1'b0, p} + 4'(k);
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < 5; i++) begin
      hit[i] = CACHE_EN && pend_q[i] && valid_q[i] &&
               (bus.cli_addr[i*AW +: AW] == tag_q[i*AW +: AW]);
    end
  end

  assign miss = pend_q & ~hit;

  // first missed client at or above the pointer, wrapping 4 -> 0
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int k = 0; k < 5; k++) begin
      if (!pick_vld && miss[rr_idx(ptr_q, k)]) begin
        pick_vld = 1'b1;
        pick     = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    ctl_req_d  = ctl_req_q;
    ctl_addr_d = ctl_addr_q;
    fill       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d      = pick;
          ctl_addr_d = bus.cli_addr[pick*AW +: AW];
          ctl_req_d  = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ctl_rdy) begin
          ctl_req_d = 1'b0;
          fill      = 1'b1;
          ptr_d     = (gnt_q == 3'd4) ? 3'd0 : gnt_q + 3'd1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdy_d   = hit;
    tag_d   = tag_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    if (fill) begin
      rdy_d[gnt_q]             = 1'b1;
      valid_d[gnt_q]           = 1'b1;
      tag_d[gnt_q*AW +: AW]    = ctl_addr_q;
      dout_d[gnt_q*DW +: DW]   = bus.ctl_dout;
    end
    // mask while rdy is being raised, while high, and one cycle after,
    // so a req still held from the finished access is not served again
    pend_d = bus.cli_req & ~(rdy_d | rdy_q | rdy2_q);
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      rdy_q      <= '0;
      rdy2_q     <= '0;
      valid_q    <= '0;
      tag_q      <= '0;
      dout_q     <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      ctl_req_q  <= 1'b0;
      ctl_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rdy_q      <= rdy_d;
      rdy2_q     <= rdy_q;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      dout_q     <= dout_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      ctl_req_q  <= ctl_req_d;
      ctl_addr_q <= ctl_addr_d;
    end
  end

  assign bus.cli_rdy  = rdy_q;
  assign bus.cli_dout = dout_q;
  assign bus.ctl_req  = ctl_req_q;
  assign bus.ctl_addr = ctl_addr_q;

endmodule

// File: tb/tb_xs_sdr_rom_arbiter.sv
// tb_xs_sdr_rom_arbiter: scoreboard bench for the SDRAM ROM arbiter.
// Drives five clients and a model controller; second instance has the cache off.
`timescale 1ns/1ps
module tb_xs_sdr_rom_arbiter;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int LAT = 5;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  xs_sdr_rom_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  xs_sdr_rom_arbiter_if #(.AW(AW), .DW(DW)) nbus ();

  xs_sdr_rom_arbiter #(.AW(AW), .DW(DW), .CACHE_EN(1'b1)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  xs_sdr_rom_arbiter #(.AW(AW), .DW(DW), .CACHE_EN(1'b0)) dut_nc (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (nbus)
  );

  typedef struct {
    int            c;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          exp_rdy[$];
  logic [AW-1:0] exp_ctl[$];

  int errs = 0;
  int chks = 0;
  int cyc  = 0;
  int rdy_cyc[5];
  int req_cyc[5];
  int hold[5];
  int hold_cnt[5];
  int ctl_rdy_cyc = 0;
  int cnt = 0;
  bit busy = 1'b0;
  bit auto_ctl = 1'b1;
  bit prev_req = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] cdata(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hBFEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    chks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // one clock: controller model after the edge, monitor on the falling edge
  task automatic step();
    @(posedge CLK);
    #1;
    if (bus.ctl_rdy) begin
      bus.ctl_rdy = 1'b0;
    end else if (auto_ctl) begin
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          bus.ctl_rdy  = 1'b1;
          bus.ctl_dout = cdata(bus.ctl_addr);
          busy         = 1'b0;
          ctl_rdy_cyc  = cyc;
        end
      end else if (bus.ctl_req) begin
        busy = 1'b1;
        cnt  = LAT;
      end
    end
    @(negedge CLK);
    for (int i = 0; i < 5; i++) begin
      if (bus.cli_rdy[i]) begin
        int k;
        k = -1;
        rdy_cyc[i] = cyc;
        foreach (exp_rdy[j]) if (k < 0 && exp_rdy[j].c == i) k = j;
        if (k < 0) begin
          check($sformatf("rdy%0d_unexpected", i), 32'(bus.cli_rdy[i]), 0);
        end else begin
          check($sformatf("dout%0d", i), 32'(bus.cli_dout[i*DW +: DW]),
                32'(exp_rdy[k].d));
          exp_rdy.delete(k);
        end
      end
      if (bus.cli_rdy[i] && bus.cli_req[i]) begin
        if (hold[i] == 0) begin
          bus.cli_req[i] = 1'b0;
        end else begin
          hold_cnt[i] = hold[i];
          hold[i]     = 0;
        end
      end else if (hold_cnt[i] > 0) begin
        hold_cnt[i]--;
        if (hold_cnt[i] == 0) bus.cli_req[i] = 1'b0;
      end
    end
    if (bus.ctl_req && !prev_req) begin
      if (exp_ctl.size() == 0)
        check("ctl_req_unexpected", 32'(bus.ctl_req), 0);
      else
        check("ctl_addr", 32'(bus.ctl_addr), 32'(exp_ctl.pop_front()));
    end
    prev_req = bus.ctl_req;
  endtask

  task automatic req(input int c, input logic [AW-1:0] a, input bit miss);
    bus.cli_addr[c*AW +: AW] = a;
    bus.cli_req[c]           = 1'b1;
    req_cyc[c]               = cyc;
    exp_rdy.push_back('{c, cdata(a)});
    if (miss) exp_ctl.push_back(a);
  endtask

  task automatic wait_done(input string tag);
    for (int n = 0; n < 300; n++) begin
      if (exp_rdy.size() == 0 && exp_ctl.size() == 0 &&
          bus.cli_req == 5'd0 && !bus.ctl_req && !busy) break;
      step();
    end
    repeat (3) step();
    check({tag, "_left"}, 32'(exp_rdy.size() + exp_ctl.size()), 0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    busy = 1'b0;
    bus.ctl_rdy = 1'b0;
    step();
    step();
    RSTn = 1'b1;
  endtask

  task automatic nc_txn(input logic [AW-1:0] a);
    bit seen;
    seen = 1'b0;
    nbus.cli_addr[AW-1:0] = a;
    nbus.cli_req[0]       = 1'b1;
    for (int n = 0; n < 20 && !seen; n++) begin
      step();
      seen = nbus.ctl_req;
    end
    check("nc_ctl_req", 32'(nbus.ctl_req), 1);
    if (seen) begin
      check("nc_ctl_addr", 32'(nbus.ctl_addr), 32'(a));
      step();
      nbus.ctl_dout = cdata(a);
      nbus.ctl_rdy  = 1'b1;
      step();
      nbus.ctl_rdy  = 1'b0;
      check("nc_rdy", 32'(nbus.cli_rdy[0]), 1);
      check("nc_dout", 32'(nbus.cli_dout[DW-1:0]), 32'(cdata(a)));
    end
    nbus.cli_req[0] = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    bus.cli_req   = '0;
    bus.cli_addr  = '0;
    bus.ctl_rdy   = 1'b0;
    bus.ctl_dout  = '0;
    nbus.cli_req  = '0;
    nbus.cli_addr = '0;
    nbus.ctl_rdy  = 1'b0;
    nbus.ctl_dout = '0;
    for (int i = 0; i < 5; i++) begin
      hold[i]     = 0;
      hold_cnt[i] = 0;
      rdy_cyc[i]  = 0;
      req_cyc[i]  = 0;
    end

    RSTn = 1'b0;
    step();
    step();
    check("rst_cli_rdy", 32'(bus.cli_rdy), 0);
    check("rst_cli_dout", 32'(bus.cli_dout[31:0]), 0);
    check("rst_ctl_req", 32'(bus.ctl_req), 0);
    check("rst_ctl_addr", 32'(bus.ctl_addr), 0);
    RSTn = 1'b1;
    step();

    // single miss
    req(0, 25'h000100, 1'b1);
    wait_done("t1");
    check("t1_lat", 32'(rdy_cyc[0] - req_cyc[0]), 8);
    check("t1_ctl2cli", 32'(rdy_cyc[0] - ctl_rdy_cyc), 1);

    // repeat of the same address hits
    req(0, 25'h000100, 1'b0);
    wait_done("t2");
    check("t2_lat", 32'(rdy_cyc[0] - req_cyc[0]), 2);

    // all five at once from pointer 0
    do_reset();
    for (int i = 0; i < 5; i++) req(i, 25'(32'h1000 * (i + 1)), 1'b1);
    wait_done("t3");
    req(2, 25'h0ABC00, 1'b1);
    req(4, 25'h0DEF00, 1'b1);
    wait_done("t3b");

    // held req after rdy: one miss then exactly one hit
    hold[3] = 3;
    req(3, 25'h003333, 1'b1);
    exp_rdy.push_back('{3, cdata(25'h003333)});
    wait_done("t4");

    // bg1 hit alongside an scpu miss
    req(3, 25'h003333, 1'b0);
    req(1, 25'h005555, 1'b1);
    wait_done("t6");
    check("t6_hit_lat", 32'(rdy_cyc[3] - req_cyc[3]), 2);
    check("t6_miss_lat", 32'(rdy_cyc[1] - req_cyc[1]), 8);

    // reset while waiting on the controller, then a stray ctl_rdy
    auto_ctl = 1'b0;
    bus.cli_addr[AW-1:0] = 25'h00AAAA;
    bus.cli_req[0] = 1'b1;
    exp_ctl.push_back(25'h00AAAA);
    for (int n = 0; n < 20 && !bus.ctl_req; n++) step();
    check("t5_ctl_up", 32'(bus.ctl_req), 1);
    step();
    step();
    bus.cli_req[0] = 1'b0;
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    check("t5_ctl_drop", 32'(bus.ctl_req), 0);
    bus.ctl_dout = 16'h1234;
    bus.ctl_rdy  = 1'b1;
    repeat (4) step();
    check("t5_ctl_req", 32'(bus.ctl_req), 0);
    check("t5_dout0", 32'(bus.cli_dout[DW-1:0]), 0);
    auto_ctl = 1'b1;
    req(0, 25'h001000, 1'b1);
    wait_done("t5");

    // cache disabled: every access reaches the controller
    nc_txn(25'h000100);
    nc_txn(25'h000100);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
